e32_host_controller: RTL and testbench



---
 rtl/e32_host_pkg.sv | 57 +++++
 rtl/e32_aux_waiter.sv | 48 ++++
 rtl/e32_host_controller.sv | 201 ++++++++++++++++++++
 tb/tb_e32_host_controller.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e32_host_pkg.sv
// Shared definitions for the E32 transceiver host controller: opcodes, frame
// header bytes, FSM states, status codes and frame lengths.
package e32_host_pkg;

  typedef enum logic [1:0] {
    OP_WRITE_VOL   = 2'b00,
    OP_WRITE_SAVED = 2'b01,
    OP_READ_CFG    = 2'b10,
    OP_READ_VER    = 2'b11
  } op_t;

  localparam logic [7:0] HDR_C0 = 8'hC0;
  localparam logic [7:0] HDR_C1 = 8'hC1;
  localparam logic [7:0] HDR_C2 = 8'hC2;
  localparam logic [7:0] HDR_C3 = 8'hC3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MODE_SET,
    ST_AUX_WAIT,
    ST_SEND,
    ST_RECV,
    ST_RESTORE,
    ST_RESTORE_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK          = 2'b00,
    ERR_AUX_TIMEOUT = 2'b01,
    ERR_RSP_TIMEOUT = 2'b10,
    ERR_HDR         = 2'b11
  } err_t;

  localparam logic [2:0] WRITE_LEN   = 3'd6;
  localparam logic [2:0] READ_LEN    = 3'd3;
  localparam logic [2:0] CFG_RSP_LEN = 3'd6;
  localparam logic [2:0] VER_RSP_LEN = 3'd4;

  // Width that holds the largest of three cycle limits without wrapping.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction

  function automatic logic [7:0] op_header(input op_t op);
    case (op)
      OP_WRITE_VOL:   return HDR_C2;
      OP_WRITE_SAVED: return HDR_C0;
      OP_READ_CFG:    return HDR_C1;
      default:        return HDR_C3;
    endcase
  endfunction

endpackage

// File: rtl/e32_aux_waiter.sv
// Synchronises the transceiver AUX pin, waits out the mode-change guard time,
// then reports AUX ready (done) or a bounded wait expiring (timeout).
module e32_aux_waiter #(
  parameter int MODE_GUARD_CYCLES  = 5000,
  parameter int AUX_TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W              = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic aux,
  output logic done,
  output logic timeout
);

  localparam logic [CNT_W-1:0] GUARD_MAX = CNT_W'(MODE_GUARD_CYCLES);
  localparam logic [CNT_W-1:0] TO_MAX    = CNT_W'(AUX_TIMEOUT_CYCLES);

  logic [1:0]       aux_sync_q;
  logic [CNT_W-1:0] guard_q;
  logic [CNT_W-1:0] to_q;
  logic             guard_done;

  assign guard_done = (guard_q == GUARD_MAX);

  // Counters restart whenever the waiter is disabled, so each wait starts fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      aux_sync_q <= 2'b00;
      guard_q    <= '0;
      to_q       <= '0;
    end else begin
      aux_sync_q <= {aux_sync_q[0], aux};
      if (!enable) begin
        guard_q <= '0;
        to_q    <= '0;
      end else if (!guard_done) begin
        guard_q <= guard_q + 1'b1;
      end else if (!aux_sync_q[1] && to_q != TO_MAX) begin
        to_q <= to_q + 1'b1;
      end
    end
  end

  assign done    = enable && guard_done && aux_sync_q[1];
  assign timeout = enable && guard_done && !aux_sync_q[1] && (to_q == TO_MAX);

endmodule

// File: rtl/e32_host_controller.sv
// Host-side controller for an E32 LoRa transceiver: switches to sleep mode,
// sends a config/version command frame, collects the reply, restores the mode.
module e32_host_controller
  import e32_host_pkg::*;
#(
  parameter int MODE_GUARD_CYCLES  = 5000,
  parameter int AUX_TIMEOUT_CYCLES = 1000000,
  parameter int RSP_TIMEOUT_CYCLES = 500000
) (
  input  logic        device_clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [39:0] cfg_in,
  input  logic [1:0]  mode_req,
  output logic        M0,
  output logic        M1,
  input  logic        AUX,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rsp_valid,
  output logic [47:0] rsp_data,
  output logic [1:0]  rsp_err,
  output logic        busy,
  output state_t      state_dbg
);

  localparam int CNT_W = cnt_width(MODE_GUARD_CYCLES, AUX_TIMEOUT_CYCLES, RSP_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] RSP_MAX = CNT_W'(RSP_TIMEOUT_CYCLES);

  state_t           state_q, state_d;
  op_t              op_q;
  logic [39:0]      cfg_q;
  logic [1:0]       m_q;
  logic [2:0]       idx_q;
  logic [47:0]      buf_q;
  err_t             err_q, err_d;
  logic [47:0]      rsp_data_q;
  err_t             rsp_err_q;
  logic [CNT_W-1:0] rsp_cnt_q;

  logic       is_write, aux_enable, aux_done, aux_timeout;
  logic       tx_fire, tx_last, rx_take, rx_last, rsp_timeout;
  logic [2:0] frame_len, rsp_len;
  logic [7:0] rsp_hdr, tx_byte;

  assign is_write    = ~op_q[1];
  assign frame_len   = is_write ? WRITE_LEN : READ_LEN;
  assign rsp_len     = (op_q == OP_READ_CFG) ? CFG_RSP_LEN : VER_RSP_LEN;
  assign rsp_hdr     = (op_q == OP_READ_CFG) ? HDR_C0 : HDR_C3;
  assign aux_enable  = (state_q == ST_AUX_WAIT) || (state_q == ST_RESTORE_WAIT);
  // valid/ready: a byte or command moves only on a cycle where both are high;
  // the producer holds valid and data unchanged until that cycle.
  assign tx_fire     = (state_q == ST_SEND) && tx_ready;
  assign tx_last     = (idx_q == frame_len - 3'd1);
  assign rx_take     = (state_q == ST_RECV) && rx_valid && (idx_q < rsp_len);
  assign rx_last     = (idx_q == rsp_len - 3'd1);
  assign rsp_timeout = (state_q == ST_RECV) && !rx_valid && (rsp_cnt_q == RSP_MAX);

  e32_aux_waiter #(
    .MODE_GUARD_CYCLES (MODE_GUARD_CYCLES),
    .AUX_TIMEOUT_CYCLES(AUX_TIMEOUT_CYCLES),
    .CNT_W             (CNT_W)
  ) u_aux_waiter (
    .clk    (device_clk),
    .rst    (rst),
    .enable (aux_enable),
    .aux    (AUX),
    .done   (aux_done),
    .timeout(aux_timeout)
  );

  always_comb begin
    tx_byte = op_header(op_q);
    if (is_write) begin
      case (idx_q)
        3'd1:    tx_byte = cfg_q[39:32];
        3'd2:    tx_byte = cfg_q[31:24];
        3'd3:    tx_byte = cfg_q[23:16];
        3'd4:    tx_byte = cfg_q[15:8];
        3'd5:    tx_byte = cfg_q[7:0];
        default: tx_byte = op_header(op_q);
      endcase
    end
  end

  // Only the first error of an operation is kept.
  always_comb begin
    err_d = err_q;
    if (err_q == ERR_OK) begin
      if (aux_timeout)      err_d = ERR_AUX_TIMEOUT;
      else if (rsp_timeout) err_d = ERR_RSP_TIMEOUT;
      else if (rx_take && idx_q == 3'd0 && rx_data != rsp_hdr) err_d = ERR_HDR;
    end
  end

  always_ff @(posedge device_clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    tx_valid  = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy      = 1'b0;
        cmd_ready = !rst;
        if (cmd_valid) state_d = ST_MODE_SET;
      end
      ST_MODE_SET: state_d = ST_AUX_WAIT;
      ST_AUX_WAIT: begin
        if (aux_done)         state_d = ST_SEND;
        else if (aux_timeout) state_d = ST_RESTORE;
      end
      ST_SEND: begin
        tx_valid = 1'b1;
        if (tx_fire && tx_last) state_d = is_write ? ST_RESTORE : ST_RECV;
      end
      ST_RECV: begin
        if ((rx_take && rx_last) || rsp_timeout) state_d = ST_RESTORE;
      end
      ST_RESTORE: state_d = ST_RESTORE_WAIT;
      ST_RESTORE_WAIT: begin
        if (aux_done || aux_timeout) state_d = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge device_clk) begin
    if (rst) begin
      op_q       <= OP_WRITE_VOL;
      cfg_q      <= '0;
      m_q        <= 2'b00;
      idx_q      <= '0;
      buf_q      <= '0;
      err_q      <= ERR_OK;
      rsp_data_q <= '0;
      rsp_err_q  <= ERR_OK;
      rsp_cnt_q  <= '0;
    end else begin
      err_q <= (state_q == ST_IDLE) ? ERR_OK : err_d;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q      <= op_t'(cmd_op);
            cfg_q     <= cfg_in;
            m_q       <= 2'b11;
            idx_q     <= '0;
            buf_q     <= '0;
            rsp_cnt_q <= '0;
          end else begin
            m_q <= mode_req;
          end
        end
        ST_SEND: begin
          if (tx_fire) idx_q <= tx_last ? 3'd0 : idx_q + 3'd1;
        end
        ST_RECV: begin
          if (rx_take) begin
            for (int i = 0; i < 6; i++) begin
              if (idx_q == 3'(i)) buf_q[8*(5-i) +: 8] <= rx_data;
            end
            idx_q     <= idx_q + 3'd1;
            rsp_cnt_q <= '0;
          end else if (rsp_cnt_q != RSP_MAX) begin
            rsp_cnt_q <= rsp_cnt_q + 1'b1;
          end
        end
        ST_RESTORE: m_q <= mode_req;
        ST_RESTORE_WAIT: begin
          if (aux_done || aux_timeout) begin
            rsp_data_q <= buf_q;
            rsp_err_q  <= err_d;
          end
        end
        default: ;
      endcase
    end
  end

  assign M1        = m_q[1];
  assign M0        = m_q[0];
  assign tx_data   = tx_byte;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_e32_host_controller.sv
// Directed bench for e32_host_controller with tx/response scoreboards.
module tb_e32_host_controller;
  import e32_host_pkg::*;

  localparam int GUARD  = 4;
  localparam int AUX_TO = 20;
  localparam int RSP_TO = 30;

  logic        device_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [39:0] cfg_in = '0;
  logic [1:0]  mode_req = 2'b01;
  logic        M0, M1;
  logic        AUX = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rsp_valid;
  logic [47:0] rsp_data;
  logic [1:0]  rsp_err;
  logic        busy;
  state_t      state_dbg;

  logic [7:0]  tx_exp_q[$];
  logic [49:0] rsp_exp_q[$];
  int          checks = 0;
  int          failures = 0;
  bit          tx_rand = 1'b0;

  e32_host_controller #(
    .MODE_GUARD_CYCLES (GUARD),
    .AUX_TIMEOUT_CYCLES(AUX_TO),
    .RSP_TIMEOUT_CYCLES(RSP_TO)
  ) dut (
    .device_clk(device_clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cfg_in(cfg_in),
    .mode_req(mode_req), .M0(M0), .M1(M1), .AUX(AUX),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .state_dbg(state_dbg)
  );

  // Clock and tx_ready back-pressure.
  always #5 device_clk = ~device_clk;

  always @(posedge device_clk) begin
    #1;
    tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge device_clk);
      #1;
    end
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [39:0] cfg);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      tick(1);
      n++;
    end
    cmd_op    = op;
    cfg_in    = cfg;
    cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] hdr, input logic [39:0] cfg, input bit wr);
    tx_exp_q.push_back(hdr);
    if (wr) begin
      for (int i = 4; i >= 0; i--) tx_exp_q.push_back(cfg[8*i +: 8]);
    end else begin
      tx_exp_q.push_back(hdr);
      tx_exp_q.push_back(hdr);
    end
  endtask

  task automatic wait_tx(input int limit, input string tag);
    int n = 0;
    while (tx_exp_q.size() != 0 && n < limit) begin
      tick(1);
      n++;
    end
    checks++;
    assert (tx_exp_q.size() == 0) else begin
      failures++;
      $error("FAIL %s_tx_timeout pending=%0d expected=0", tag, tx_exp_q.size());
    end
  endtask

  task automatic wait_rsp(input int limit, input string tag);
    int n = 0;
    while (rsp_exp_q.size() != 0 && n < limit) begin
      tick(1);
      n++;
    end
    checks++;
    assert (rsp_exp_q.size() == 0) else begin
      failures++;
      $error("FAIL %s_rsp_timeout pending=%0d expected=0", tag, rsp_exp_q.size());
    end
  endtask

  // Scoreboard: tx bytes in order, with hold-while-stalled checking.
  bit         hold_pend = 1'b0;
  logic [7:0] held;
  always @(negedge device_clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("tx_hold_valid", 64'(tx_valid), 64'd1);
        check("tx_hold_data", 64'(tx_data), 64'(held));
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        checks++;
        assert (tx_exp_q.size() > 0) else begin
          failures++;
          $error("FAIL tx_unexpected observed=%0h expected=none", tx_data);
        end
        if (tx_exp_q.size() > 0) check("tx_byte", 64'(tx_data), 64'(tx_exp_q.pop_front()));
        hold_pend = 1'b0;
      end else if (tx_valid === 1'b1) begin
        hold_pend = 1'b1;
        held      = tx_data;
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  // Scoreboard: completions {rsp_err, rsp_data} and single-cycle pulse.
  bit rsp_prev = 1'b0;
  always @(negedge device_clk) begin
    if (rst) begin
      rsp_prev = 1'b0;
    end else begin
      if (rsp_prev) check("rsp_valid_one_cycle", 64'(rsp_valid), 64'd0);
      if (rsp_valid === 1'b1) begin
        checks++;
        assert (rsp_exp_q.size() > 0) else begin
          failures++;
          $error("FAIL rsp_unexpected observed=%0h expected=none", {rsp_err, rsp_data});
        end
        if (rsp_exp_q.size() > 0) check("rsp", 64'({rsp_err, rsp_data}), 64'(rsp_exp_q.pop_front()));
      end
      rsp_prev = rsp_valid;
    end
  end

  initial begin
    logic [39:0] cfg_r;

    // Reset state.
    tick(3);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_tx_valid", 64'(tx_valid), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_data", 64'(rsp_data), 64'd0);
    check("reset_rsp_err", 64'(rsp_err), 64'd0);
    check("reset_m", 64'({M1, M0}), 64'd0);
    check("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);
    tick(1);
    check("idle_m_follows_req", 64'({M1, M0}), 64'd1);

    // Write saved config.
    push_tx(HDR_C0, 40'h0000_1A17_44, 1'b1);
    rsp_exp_q.push_back({ERR_OK, 48'h0});
    issue_cmd(OP_WRITE_SAVED, 40'h0000_1A17_44);
    check("m_sleep_during_cmd", 64'({M1, M0}), 64'd3);
    check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
    wait_rsp(300, "write_saved");
    check("m_restored", 64'({M1, M0}), 64'd1);
    tick(3);
    check("rsp_err_hold", 64'(rsp_err), 64'd0);

    // Write volatile with random back-pressure.
    tx_rand = 1'b1;
    cfg_r = {8'($urandom_range(0, 255)), 32'($urandom)};
    push_tx(HDR_C2, cfg_r, 1'b1);
    rsp_exp_q.push_back({ERR_OK, 48'h0});
    issue_cmd(OP_WRITE_VOL, cfg_r);
    wait_rsp(400, "write_vol");
    tx_rand = 1'b0;

    // Read version, stray byte before RECV and extra byte after.
    push_tx(HDR_C3, 40'h0, 1'b0);
    rsp_exp_q.push_back({ERR_OK, 48'hC332_2702_0000});
    issue_cmd(OP_READ_VER, 40'h0);
    send_rx(8'h55);
    wait_tx(200, "read_ver");
    send_rx(8'hC3); send_rx(8'h32); send_rx(8'h27); send_rx(8'h02); send_rx(8'h99);
    wait_rsp(300, "read_ver");
    tick(3);
    check("rsp_data_hold", 64'(rsp_data), 64'hC332_2702_0000);

    // AUX stuck low: no frame, restore with the mode requested at that time.
    AUX = 1'b0;
    rsp_exp_q.push_back({ERR_AUX_TIMEOUT, 48'h0});
    issue_cmd(OP_READ_CFG, 40'h0);
    tick(2);
    mode_req = 2'b10;
    wait_rsp(300, "aux_timeout");
    check("m_restored_aux_to", 64'({M1, M0}), 64'd2);
    AUX = 1'b1;
    mode_req = 2'b01;
    tick(4);

    // Read config, reply stops after three bytes.
    push_tx(HDR_C1, 40'h0, 1'b0);
    rsp_exp_q.push_back({ERR_RSP_TIMEOUT, 48'hC011_2200_0000});
    issue_cmd(OP_READ_CFG, 40'h0);
    wait_tx(200, "rsp_timeout");
    send_rx(8'hC0); send_rx(8'h11); send_rx(8'h22);
    wait_rsp(300, "rsp_timeout");

    // Read version with bad header; cmd_valid held while busy.
    push_tx(HDR_C3, 40'h0, 1'b0);
    rsp_exp_q.push_back({ERR_HDR, 48'hAA01_0203_0000});
    issue_cmd(OP_READ_VER, 40'h0);
    cmd_op    = OP_WRITE_VOL;
    cmd_valid = 1'b1;
    tick(1);
    check("busy_cmd_ready_low", 64'(cmd_ready), 64'd0);
    wait_tx(200, "hdr_err");
    send_rx(8'hAA); send_rx(8'h01); send_rx(8'h02); send_rx(8'h03);
    cmd_valid = 1'b0;
    wait_rsp(300, "hdr_err");
    tick(3);
    check("busy_cmd_ignored", 64'(busy), 64'd0);

    // Reset in the middle of SEND with back-pressure.
    tx_rand = 1'b1;
    push_tx(HDR_C2, 40'h11_2233_4455, 1'b1);
    issue_cmd(OP_WRITE_VOL, 40'h11_2233_4455);
    for (int n = 0; n < 100 && tx_valid !== 1'b1; n++) tick(1);
    check("send_reached", 64'(tx_valid), 64'd1);
    tick(3);
    rst = 1'b1;
    tick(1);
    check("midrst_tx_valid", 64'(tx_valid), 64'd0);
    check("midrst_m", 64'({M1, M0}), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_rsp_data", 64'(rsp_data), 64'd0);
    check("midrst_rsp_err", 64'(rsp_err), 64'd0);
    check("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
    tx_exp_q.delete();
    rst = 1'b0;
    #1;
    check("midrst_cmd_ready_release", 64'(cmd_ready), 64'd1);
    tx_rand = 1'b0;
    tick(1);

    // Full six-byte config read.
    push_tx(HDR_C1, 40'h0, 1'b0);
    rsp_exp_q.push_back({ERR_OK, 48'hC012_3456_789A});
    issue_cmd(OP_READ_CFG, 40'h0);
    wait_tx(200, "read_cfg");
    send_rx(8'hC0); send_rx(8'h12); send_rx(8'h34);
    send_rx(8'h56); send_rx(8'h78); send_rx(8'h9A);
    wait_rsp(300, "read_cfg");

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
